// File: rtl/piso_serializer.sv
// Parallel-in/serial-out word serializer with valid/ready intake,
// optional inter-word idle gap and synchronous abort.
module piso_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned GAP       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pdata,
    input  logic             pvalid,
    output logic             pready,
    input  logic             abort,
    output logic             sdout,
    output logic             sdout_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [3:0] GAP_LAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);
    localparam bit NO_GAP = (GAP == 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       gcnt_q, gcnt_d;

    logic             in_shift;
    logic             last_bit;
    logic             cur_bit;
    logic             xfer;
    logic [WIDTH-1:0] sh_next;

    assign in_shift = (state_q == ST_SHIFT);
    assign last_bit = in_shift && (cnt_q == LAST_CNT);

    // The bit on the wire is always the leading end of the shift register.
    assign cur_bit = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];
    assign sh_next = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0}
                               : {1'b0, sh_q[WIDTH-1:1]};

    assign pready = ~reset & ~abort &
                    ((state_q == ST_IDLE) | (last_bit & NO_GAP));
    assign xfer   = pvalid & pready;

    assign sdout_valid = in_shift;
    assign sdout       = in_shift & cur_bit;
    assign busy        = (state_q != ST_IDLE);
    assign word_done   = last_bit & ~abort;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            gcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            sh_d    = '0;
            cnt_d   = '0;
            gcnt_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (xfer) begin
                        state_d = ST_SHIFT;
                        sh_d    = pdata;
                        cnt_d   = '0;
                    end
                end
                ST_SHIFT: begin
                    if (last_bit) begin
                        cnt_d = '0;
                        if (xfer) begin
                            // Gapless reload: next word starts right after.
                            sh_d = pdata;
                        end else if (NO_GAP) begin
                            state_d = ST_IDLE;
                            sh_d    = '0;
                        end else begin
                            state_d = ST_GAP;
                            sh_d    = '0;
                            gcnt_d  = '0;
                        end
                    end else begin
                        sh_d  = sh_next;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gcnt_q == GAP_LAST) begin
                        state_d = ST_IDLE;
                        gcnt_d  = '0;
                    end else begin
                        gcnt_d = gcnt_q + 4'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    sh_d    = '0;
                    cnt_d   = '0;
                    gcnt_d  = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: two instances (MSB-first/no gap and
// LSB-first/gap 2) checked every cycle against a bit-sequence model.
module tb_piso_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      reset, abort, pvalid;
    logic [1:0][7:0] pdata;
    logic [1:0]      pready, sdout, sdv, busy, wd;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(0)) u0 (
        .clk(clk), .reset(reset[0]), .pdata(pdata[0]),
        .pvalid(pvalid[0]), .pready(pready[0]), .abort(abort[0]),
        .sdout(sdout[0]), .sdout_valid(sdv[0]), .busy(busy[0]),
        .word_done(wd[0])
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(2)) u1 (
        .clk(clk), .reset(reset[1]), .pdata(pdata[1]),
        .pvalid(pvalid[1]), .pready(pready[1]), .abort(abort[1]),
        .sdout(sdout[1]), .sdout_valid(sdv[1]), .busy(busy[1]),
        .word_done(wd[1])
    );

    int errors = 0;
    int checks = 0;

    // Reference: remaining payload bits of the current word, gap cycles left.
    bit seq [2][8];
    int rem [2];
    int gapl [2];
    int GAPP [2] = '{0, 2};
    bit MSBF [2] = '{1'b1, 1'b0};

    logic [1:0] obs_rdy, obs_sd, obs_v, obs_busy, obs_wd;

    function automatic logic [4:0] model_out(int k);
        logic rdy, sd, v, b, d;
        v   = (rem[k] > 0);
        sd  = v ? seq[k][8 - rem[k]] : 1'b0;
        d   = (rem[k] == 1) && !abort[k];
        b   = v || (gapl[k] > 0);
        rdy = !reset[k] && !abort[k] &&
              ((!v && gapl[k] == 0) || (rem[k] == 1 && GAPP[k] == 0));
        return {rdy, sd, v, b, d};
    endfunction

    task automatic model_tick(int k);
        logic [4:0] o;
        bit xfer;
        o    = model_out(k);
        xfer = pvalid[k] && o[4];
        if (reset[k] || abort[k]) begin
            rem[k]  = 0;
            gapl[k] = 0;
        end else begin
            if (rem[k] > 0) begin
                rem[k]--;
                if (rem[k] == 0 && GAPP[k] > 0) gapl[k] = GAPP[k];
            end else if (gapl[k] > 0) begin
                gapl[k]--;
            end
            if (xfer) begin
                for (int i = 0; i < 8; i++)
                    seq[k][i] = MSBF[k] ? pdata[k][7-i] : pdata[k][i];
                rem[k] = 8;
            end
        end
    endtask

    task automatic step();
        logic [4:0] got, exp;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            got = {pready[k], sdout[k], sdv[k], busy[k], wd[k]};
            exp = model_out(k);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL cycle u%0d rdy/sd/v/busy/done: got %b required %b",
                         k, got, exp);
            end
            obs_rdy[k]  = pready[k];
            obs_sd[k]   = sdout[k];
            obs_v[k]    = sdv[k];
            obs_busy[k] = busy[k];
            obs_wd[k]   = wd[k];
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_tick(k);
        #1;
    endtask

    task automatic check(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic accept(int k, logic [7:0] d, bit hold);
        bit ok;
        ok        = 1'b0;
        pvalid[k] = 1'b1;
        pdata[k]  = d;
        for (int c = 0; c < 30; c++) begin
            step();
            if (obs_rdy[k]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!hold) pvalid[k] = 1'b0;
        check("accept_timeout", int'(ok), 1);
    endtask

    task automatic drain(int k);
        for (int c = 0; c < 30; c++) begin
            step();
            if (!obs_busy[k]) break;
        end
    endtask

    task automatic capture(int k, output logic [7:0] bits);
        int nb;
        nb   = 0;
        bits = '0;
        for (int c = 0; c < 30 && nb < 8; c++) begin
            step();
            if (obs_v[k]) begin
                bits = {bits[6:0], obs_sd[k]};
                nb++;
            end
        end
        check("capture_count", nb, 8);
    endtask

    typedef struct {
        int         k;
        logic [7:0] d;
        logic [7:0] exp_bits;
        string      name;
    } vec_t;

    vec_t tbl [8];
    logic [7:0] bits;
    int n, nv;

    initial begin
        reset  = 2'b11;
        abort  = '0;
        pvalid = '0;
        pdata  = '0;
        for (int k = 0; k < 2; k++) begin
            rem[k]  = 0;
            gapl[k] = 0;
        end
        step();
        step();
        check("reset_pready", int'(obs_rdy), 0);
        check("reset_busy", int'(obs_busy | obs_v), 0);
        reset = 2'b00;
        step();
        check("idle_pready", int'(obs_rdy), 3);

        tbl[0] = '{0, 8'hB0, 8'b10110000, "msb_B0"};
        tbl[1] = '{1, 8'h0D, 8'b10110000, "lsb_0D"};
        tbl[2] = '{0, 8'hA5, 8'b10100101, "msb_A5"};
        tbl[3] = '{1, 8'h3C, 8'b00111100, "lsb_3C"};
        tbl[4] = '{0, 8'h01, 8'b00000001, "msb_01"};
        tbl[5] = '{1, 8'h01, 8'b10000000, "lsb_01"};
        tbl[6] = '{1, 8'h80, 8'b00000001, "lsb_80"};
        tbl[7] = '{0, 8'hFF, 8'b11111111, "msb_FF"};
        for (int i = 0; i < 8; i++) begin
            accept(tbl[i].k, tbl[i].d, 1'b0);
            capture(tbl[i].k, bits);
            check(tbl[i].name, int'(bits), int'(tbl[i].exp_bits));
            drain(tbl[i].k);
        end

        // Back-to-back gapless words.
        accept(0, 8'hA5, 1'b1);
        pdata[0] = 8'h3C;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            n++;
            if (obs_rdy[0]) break;
        end
        pvalid[0] = 1'b0;
        check("b2b_ready_spacing", n, 8);
        nv = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (obs_v[0]) nv++;
        end
        check("b2b_tail_bits", nv, 8);

        // Gap of two cycles between queued words.
        accept(1, 8'h55, 1'b1);
        pdata[1] = 8'h96;
        for (int c = 0; c < 20; c++) begin
            step();
            if (obs_wd[1]) break;
        end
        n = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            n++;
            if (obs_v[1]) break;
        end
        pvalid[1] = 1'b0;
        check("gap_restart_latency", n, 4);
        drain(1);

        // Abort during the 4th bit.
        accept(0, 8'hFF, 1'b0);
        step();
        step();
        step();
        abort[0] = 1'b1;
        step();
        check("abort_no_done", int'(obs_wd[0]), 0);
        abort[0] = 1'b0;
        step();
        check("abort_idle", int'({obs_rdy[0], obs_v[0], obs_busy[0]}), 4);
        accept(0, 8'h81, 1'b0);
        capture(0, bits);
        check("after_abort_81", int'(bits), 8'h81);
        drain(0);

        // Reset during the 5th bit.
        accept(1, 8'hF7, 1'b0);
        for (int c = 0; c < 4; c++) step();
        reset[1] = 1'b1;
        step();
        step();
        check("reset_mid_out", int'({obs_rdy[1], obs_v[1], obs_busy[1]}), 0);
        reset[1] = 1'b0;
        nv = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (obs_v[1]) nv++;
        end
        check("reset_no_residue", nv, 0);
        check("reset_release_rdy", int'(obs_rdy[1]), 1);

        // Random traffic with aborts and resets.
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < 2; k++) begin
                pvalid[k] = ($urandom_range(0, 9) < 7);
                pdata[k]  = 8'($urandom);
                abort[k]  = ($urandom_range(0, 24) == 0);
                reset[k]  = ($urandom_range(0, 39) == 0);
            end
            step();
        end
        reset  = '0;
        abort  = '0;
        pvalid = '0;
        drain(0);
        drain(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
